// File: rtl/fp_stream_pkg.sv
// Shared FP32 stream definitions for the vector packer and the reduce-tree side.
// The tree-side monitor imports the same FILL/HOLD encoding so both ends agree on state names.
package fp_stream_pkg;

  typedef logic [31:0] fp32_t;

  // +0.0 is the additive identity, so padding lanes with it leaves the tree sum unchanged.
  localparam fp32_t FP32_ZERO = 32'h0000_0000;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_e;

  function automatic int lane_idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/fp_vector_packer.sv
// Packs a scalar FP32 valid/ready/last stream into NUM_FP_POINTS-lane vectors for the
// reduce tree. An assembly register collects beats; a separate output register holds the
// finished vector, so a full group can wait in assembly while the consumer is stalled.
module fp_vector_packer
  import fp_stream_pkg::*;
#(
  parameter int NUM_FP_POINTS = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [31:0]                        fp_in,
  input  logic                               fp_in_valid,
  input  logic                               fp_in_last,
  output logic                               fp_in_ready,
  output logic [NUM_FP_POINTS-1:0][31:0]     fp_out_vector,
  output logic [NUM_FP_POINTS-1:0]           fp_out_vector_valid,
  output logic [NUM_FP_POINTS-1:0]           fp_out_vector_last,
  output logic [$clog2(NUM_FP_POINTS):0]     fp_out_lanes,
  input  logic                               fp_out_ready
);

  localparam int IDX_W = lane_idx_w(NUM_FP_POINTS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FP_POINTS - 1);

  pack_state_e                  state;
  logic [IDX_W-1:0]             idx;
  fp32_t [NUM_FP_POINTS-1:0]    asm_vec;
  logic [CNT_W-1:0]             asm_lanes;
  logic                         asm_last;

  fp32_t [NUM_FP_POINTS-1:0]    out_vec;
  logic [CNT_W-1:0]             out_lanes;
  logic                         out_full;
  logic                         out_last;

  logic                         accept;
  logic                         complete;
  logic                         out_free;
  logic                         load_direct;
  logic                         load_held;
  fp32_t [NUM_FP_POINTS-1:0]    done_vec;
  logic [CNT_W-1:0]             done_lanes;

  assign fp_in_ready = (state == FILL);
  assign accept      = fp_in_valid & fp_in_ready;
  assign complete    = accept & ((idx == LAST_IDX) | fp_in_last);
  assign out_free    = ~out_full | fp_out_ready;
  assign load_direct = complete & out_free;
  assign load_held   = (state == HOLD) & out_free;
  assign done_lanes  = CNT_W'(idx) + CNT_W'(1);

  // Group as it looks once the current beat closes it: earlier lanes, this beat, then zero pads.
  always_comb begin
    done_vec = asm_vec;
    for (int k = 0; k < NUM_FP_POINTS; k++) begin
      if (IDX_W'(k) == idx) begin
        done_vec[k] = fp_in;
      end else if (IDX_W'(k) > idx) begin
        done_vec[k] = FP32_ZERO;
      end
    end
  end

  // Assembly side: collect beats, close the group, and park it in HOLD if the output is busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      idx       <= '0;
      asm_vec   <= '0;
      asm_lanes <= '0;
      asm_last  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (complete) begin
            asm_vec   <= done_vec;
            asm_lanes <= done_lanes;
            asm_last  <= fp_in_last;
            idx       <= '0;
            if (!out_free) begin
              state <= HOLD;
            end
          end else if (accept) begin
            asm_vec[idx] <= fp_in;
            idx          <= idx + IDX_W'(1);
          end
        end
        HOLD: begin
          if (out_free) begin
            state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Output register: load straight from the closing beat or from a parked group, else drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vec   <= '0;
      out_lanes <= '0;
      out_full  <= 1'b0;
      out_last  <= 1'b0;
    end else if (load_direct) begin
      out_vec   <= done_vec;
      out_lanes <= done_lanes;
      out_full  <= 1'b1;
      out_last  <= fp_in_last;
    end else if (load_held) begin
      out_vec   <= asm_vec;
      out_lanes <= asm_lanes;
      out_full  <= 1'b1;
      out_last  <= asm_last;
    end else if (out_free) begin
      out_full  <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  assign fp_out_vector       = out_vec;
  assign fp_out_vector_valid = {NUM_FP_POINTS{out_full}};
  assign fp_out_vector_last  = {NUM_FP_POINTS{out_last}};
  assign fp_out_lanes        = out_lanes;

endmodule

// File: tb/tb_fp_vector_packer.sv
// Bench for fp_vector_packer: one 8-lane and one 4-lane instance share the stimulus, with
// sel choosing which one is active. A queue model groups accepted beats into expected vectors
// and a compare process checks the active instance's outputs every cycle.
module tb_fp_vector_packer;
  import fp_stream_pkg::*;

  localparam int NA = 8;
  localparam int NB = 4;

  typedef struct packed {
    logic [NA-1:0][31:0] v;
    logic [3:0]          lanes;
    logic                last;
    int                  done_cycle;
    int                  first_cycle;
  } vec_rec_t;

  logic  clk          = 1'b0;
  logic  rst_n        = 1'b0;
  logic  sel          = 1'b0;
  fp32_t fp_in        = '0;
  logic  fp_in_valid  = 1'b0;
  logic  fp_in_last   = 1'b0;
  logic  fp_out_ready = 1'b1;
  bit    rand_on      = 1'b0;

  logic                a_in_ready;
  logic [NA-1:0][31:0] a_vec;
  logic [NA-1:0]       a_valid;
  logic [NA-1:0]       a_last;
  logic [3:0]          a_lanes;
  logic                b_in_ready;
  logic [NB-1:0][31:0] b_vec;
  logic [NB-1:0]       b_valid;
  logic [NB-1:0]       b_last;
  logic [2:0]          b_lanes;

  logic                obs_ready;
  logic                obs_valid;
  logic                obs_last;
  logic                obs_uniform;
  logic [3:0]          obs_lanes;
  logic [NA-1:0][31:0] obs_vec;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int ready_low = 0;
  int head_first = -1;
  vec_rec_t exp_q[$];
  vec_rec_t log_q[$];
  fp32_t part_q[$];

  always #5 clk = ~clk;

  fp_vector_packer #(.NUM_FP_POINTS(NA)) dut_a (
    .clk(clk), .rst_n(rst_n), .fp_in(fp_in), .fp_in_valid(fp_in_valid & ~sel),
    .fp_in_last(fp_in_last), .fp_in_ready(a_in_ready), .fp_out_vector(a_vec),
    .fp_out_vector_valid(a_valid), .fp_out_vector_last(a_last), .fp_out_lanes(a_lanes),
    .fp_out_ready(fp_out_ready)
  );

  fp_vector_packer #(.NUM_FP_POINTS(NB)) dut_b (
    .clk(clk), .rst_n(rst_n), .fp_in(fp_in), .fp_in_valid(fp_in_valid & sel),
    .fp_in_last(fp_in_last), .fp_in_ready(b_in_ready), .fp_out_vector(b_vec),
    .fp_out_vector_valid(b_valid), .fp_out_vector_last(b_last), .fp_out_lanes(b_lanes),
    .fp_out_ready(fp_out_ready)
  );

  // Present whichever instance is active as one 8-lane view, upper lanes zero for the 4-lane one.
  always_comb begin
    obs_vec = '0;
    if (!sel) begin
      obs_vec     = a_vec;
      obs_ready   = a_in_ready;
      obs_valid   = a_valid[0];
      obs_last    = a_last[0];
      obs_lanes   = a_lanes;
      obs_uniform = ((&a_valid) | ~(|a_valid)) & ((&a_last) | ~(|a_last));
    end else begin
      for (int k = 0; k < NB; k++) obs_vec[k] = b_vec[k];
      obs_ready   = b_in_ready;
      obs_valid   = b_valid[0];
      obs_last    = b_last[0];
      obs_lanes   = {1'b0, b_lanes};
      obs_uniform = ((&b_valid) | ~(|b_valid)) & ((&b_last) | ~(|b_last));
    end
  end

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
    end
  endtask

  function automatic fp32_t int_to_fp32(input int v);
    int p = 0;
    for (int i = 0; i < 24; i++) if (((v >> i) & 1) == 1) p = i;
    return {1'b0, 8'(127 + p), 23'((v << (23 - p)) & 32'h007F_FFFF)};
  endfunction

  function automatic real fp32_to_real(input fp32_t b);
    real m;
    int  e;
    if (b[30:0] == 31'd0) return 0.0;
    e = int'(b[30:23]) - 127;
    m = 1.0 + real'(int'(b[22:0])) / 8388608.0;
    if (e >= 0) for (int i = 0; i < e; i++) m = m * 2.0;
    else        for (int i = 0; i < -e; i++) m = m / 2.0;
    return b[31] ? -m : m;
  endfunction

  // Compare then model: outputs are checked against the head of the expected queue while valid,
  // and the beat about to be accepted is grouped into lanes of N or closed early by last.
  always @(negedge clk) begin
    vec_rec_t rec;
    int n;
    cycle++;
    n = sel ? NB : NA;
    if (!rst_n) begin
      part_q.delete();
      exp_q.delete();
      head_first = -1;
    end else begin
      if (!obs_ready) ready_low++;
      checkOutput("lanes_uniform", 256'(obs_uniform), 256'(1));
      if (obs_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_vector", 256'(obs_valid), 256'(0));
        end else begin
          if (head_first < 0) head_first = cycle;
          checkOutput("vector", obs_vec, exp_q[0].v);
          checkOutput("lanes", 256'(obs_lanes), 256'(exp_q[0].lanes));
          checkOutput("last", 256'(obs_last), 256'(exp_q[0].last));
          if (fp_out_ready) begin
            rec             = exp_q[0];
            rec.v           = obs_vec;
            rec.lanes       = obs_lanes;
            rec.last        = obs_last;
            rec.first_cycle = head_first;
            log_q.push_back(rec);
            void'(exp_q.pop_front());
            head_first = -1;
          end
        end
      end
      if (fp_in_valid && obs_ready) begin
        part_q.push_back(fp_in);
        if (part_q.size() == n || fp_in_last) begin
          rec.v = '0;
          foreach (part_q[i]) rec.v[i] = part_q[i];
          rec.lanes       = 4'(part_q.size());
          rec.last        = fp_in_last;
          rec.done_cycle  = cycle;
          rec.first_cycle = -1;
          exp_q.push_back(rec);
          part_q.delete();
        end
      end
    end
  end

  task automatic applyStimulus(input fp32_t value, input logic last);
    int guard = 0;
    fp_in       = value;
    fp_in_last  = last;
    fp_in_valid = 1'b1;
    do begin
      @(negedge clk);
      guard++;
    end while (!obs_ready && guard < 200);
    checkOutput("accept_timeout", 256'(obs_ready), 256'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    fp_in_valid = 1'b0;
    fp_in       = $urandom;
    fp_in_last  = 1'($urandom_range(0, 1));
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int guard = 0;
    fp_in_valid  = 1'b0;
    fp_out_ready = 1'b1;
    while ((exp_q.size() != 0 || obs_valid) && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("drain_pending", 256'(exp_q.size()), 256'(0));
    idle(2);
  endtask

  task automatic randomRun(input int beats);
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < beats; i++) begin
          int gap;
          gap = $urandom_range(0, 2);
          if (gap != 0) idle(gap);
          applyStimulus($urandom, (i == beats - 1) || ($urandom_range(0, 7) == 0));
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          fp_out_ready = ($urandom_range(0, 3) != 0);
        end
        fp_out_ready = 1'b1;
      end
    join
    drain();
  endtask

  // Guard against a hung run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: still running at %0t, wanted finish", $time);
    $fatal(1, "[TB] timeout");
  end

  // Directed scenarios with hand-computed expectations, then random traffic on both widths.
  initial begin
    int  rl;
    real sum;

    #2;
    checkOutput("reset_a_outputs", {a_vec[7:1], 4'(a_valid), 4'(a_last), a_lanes}, '0);
    checkOutput("reset_b_outputs", {b_vec, b_valid, b_last, b_lanes}, '0);
    checkOutput("reset_ready", 256'({a_in_ready, b_in_ready}), 256'(2'b11));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // N=8: 16 beats 1.0..16.0, last on beat 16, consumer always ready.
    log_q.delete();
    rl = ready_low;
    for (int v = 1; v <= 16; v++) applyStimulus(int_to_fp32(v), v == 16);
    drain();
    checkOutput("t1_count", 256'(log_q.size()), 256'(2));
    checkOutput("t1_no_ready_drop", 256'(ready_low - rl), 256'(0));
    if (log_q.size() >= 2) begin
      checkOutput("t1_v0_lane0", log_q[0].v[0], 256'(32'h3F80_0000));
      checkOutput("t1_v0_lane7", log_q[0].v[7], 256'(32'h4100_0000));
      checkOutput("t1_v0_meta", 256'({log_q[0].lanes, log_q[0].last}), 256'({4'd8, 1'b0}));
      checkOutput("t1_v1_lane0", log_q[1].v[0], 256'(32'h4110_0000));
      checkOutput("t1_v1_lane7", log_q[1].v[7], 256'(32'h4180_0000));
      checkOutput("t1_v1_meta", 256'({log_q[1].lanes, log_q[1].last}), 256'({4'd8, 1'b1}));
      checkOutput("t1_throughput", 256'(log_q[1].done_cycle - log_q[0].done_cycle), 256'(8));
    end

    // N=8: short packet 2.0, 3.0, 4.0 padded with +0.0.
    log_q.delete();
    applyStimulus(32'h4000_0000, 1'b0);
    applyStimulus(32'h4040_0000, 1'b0);
    applyStimulus(32'h4080_0000, 1'b1);
    drain();
    checkOutput("t2_count", 256'(log_q.size()), 256'(1));
    if (log_q.size() >= 1) begin
      checkOutput("t2_vector", log_q[0].v, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                            32'h4080_0000, 32'h4040_0000, 32'h4000_0000});
      checkOutput("t2_meta", 256'({log_q[0].lanes, log_q[0].last}), 256'({4'd3, 1'b1}));
      sum = 0.0;
      for (int k = 0; k < NA; k++) sum = sum + fp32_to_real(log_q[0].v[k]);
      checkOutput("t2_tree_sum", 256'($realtobits(sum)), 256'(64'h4022_0000_0000_0000));
    end

    // N=4: 12 continuous beats while the consumer stalls for 10 cycles.
    sel = 1'b1;
    idle(2);
    log_q.delete();
    rl = ready_low;
    fork
      begin
        for (int v = 1; v <= 12; v++) applyStimulus(int_to_fp32(v), v == 12);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        fp_out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        fp_out_ready = 1'b1;
      end
    join
    drain();
    checkOutput("t3_count", 256'(log_q.size()), 256'(3));
    checkOutput("t3_hold_entered", 256'((ready_low - rl) > 0), 256'(1));
    if (log_q.size() >= 3) begin
      checkOutput("t3_v0", log_q[0].v, {128'h0, 32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000});
      checkOutput("t3_v1", log_q[1].v, {128'h0, 32'h4100_0000, 32'h40E0_0000, 32'h40C0_0000, 32'h40A0_0000});
      checkOutput("t3_v2", log_q[2].v, {128'h0, 32'h4140_0000, 32'h4130_0000, 32'h4120_0000, 32'h4110_0000});
      checkOutput("t3_last", 256'({log_q[0].last, log_q[1].last, log_q[2].last}), 256'(3'b001));
      checkOutput("t3_lanes", 256'({log_q[0].lanes, log_q[1].lanes, log_q[2].lanes}), 256'({4'd4, 4'd4, 4'd4}));
    end

    // N=4: single beat 5.0 with last.
    log_q.delete();
    applyStimulus(32'h40A0_0000, 1'b1);
    drain();
    checkOutput("t4_count", 256'(log_q.size()), 256'(1));
    if (log_q.size() >= 1) begin
      checkOutput("t4_vector", log_q[0].v, {224'h0, 32'h40A0_0000});
      checkOutput("t4_meta", 256'({log_q[0].lanes, log_q[0].last}), 256'({4'd1, 1'b1}));
      checkOutput("t4_latency", 256'(log_q[0].first_cycle - log_q[0].done_cycle), 256'(1));
    end

    // N=4: reset asserted mid-clock with a held vector and two beats in assembly.
    log_q.delete();
    fp_out_ready = 1'b0;
    for (int v = 1; v <= 6; v++) applyStimulus(int_to_fp32(v), 1'b0);
    fp_in_valid = 1'b0;
    checkOutput("t5_held_before_reset", 256'(b_valid), 256'(4'hF));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_async_clear", {b_vec, b_valid, b_last, b_lanes}, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fp_out_ready = 1'b1;
    for (int v = 7; v <= 10; v++) applyStimulus(int_to_fp32(v), 1'b0);
    drain();
    checkOutput("t5_count", 256'(log_q.size()), 256'(1));
    if (log_q.size() >= 1) begin
      checkOutput("t5_vector", log_q[0].v, {128'h0, 32'h4120_0000, 32'h4110_0000, 32'h4100_0000, 32'h40E0_0000});
      checkOutput("t5_meta", 256'({log_q[0].lanes, log_q[0].last}), 256'({4'd4, 1'b0}));
    end

    // Random valid/ready/last traffic on both widths.
    randomRun(500);
    sel = 1'b0;
    idle(2);
    randomRun(500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
